// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and helpers for the fetch/MEM memory bus arbiter.
// Byte-enable encodings are bit-0 aligned as produced by decode.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_WAIT = 2'd2,
      ARB_RESP = 2'd3
   } arb_state_t;

   localparam logic [7:0] BE_B = 8'h01;
   localparam logic [7:0] BE_H = 8'h03;
   localparam logic [7:0] BE_W = 8'h0F;
   localparam logic [7:0] BE_D = 8'hFF;

   function automatic logic be_legal(input logic [7:0] be);
      return (be == BE_B) || (be == BE_H) || (be == BE_W) || (be == BE_D);
   endfunction

   function automatic logic [3:0] be_size(input logic [7:0] be);
      logic [3:0] size;
      case (be)
         BE_B:    size = 4'd1;
         BE_H:    size = 4'd2;
         BE_W:    size = 4'd4;
         default: size = 4'd8;
      endcase
      return size;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_align.sv
// Lane alignment for the 64-bit bus: shifts store data/mask up to the byte offset
// and brings load data down to bit 0 with sign or zero extension.
module mem_bus_arbiter_align
   import mem_bus_arbiter_pkg::*;
(
   input  logic [2:0]  off,
   input  logic [7:0]  be,
   input  logic        ext_un,
   input  logic [63:0] wdata,
   input  logic [63:0] rdata,
   output logic [7:0]  wmask,
   output logic [63:0] wdata_sh,
   output logic [63:0] rdata_ext,
   output logic        misalign
);

   logic [63:0] raw;
   logic        sx;

   always_comb begin
      wmask    = be << off;
      wdata_sh = wdata << {off, 3'b000};
      raw      = rdata >> {off, 3'b000};
      misalign = ({1'b0, off} + be_size(be)) > 4'd8;
      sx       = 1'b0;
      case (be)
         BE_B: begin
            sx        = ~ext_un & raw[7];
            rdata_ext = {{56{sx}}, raw[7:0]};
         end
         BE_H: begin
            sx        = ~ext_un & raw[15];
            rdata_ext = {{48{sx}}, raw[15:0]};
         end
         BE_W: begin
            sx        = ~ext_un & raw[31];
            rdata_ext = {{32{sx}}, raw[31:0]};
         end
         default: rdata_ext = raw;
      endcase
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one 64-bit memory bus between instruction fetch and the MEM stage,
// one outstanding transaction at a time, MEM having fixed priority.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ARB_IDLE | no transaction; pick MEM over IF, latch it, error-check MEM
//   ARB_REQ  | bus_valid high with latched attributes until bus_ready
//   ARB_WAIT | request accepted, waiting for bus_rvalid
//   ARB_RESP | one-cycle done pulse to the owner with captured data
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 64,
   parameter int MAX_WAIT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_rdata,
   input  logic              mem_r_ena,
   input  logic              mem_w_ena,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [63:0]       mem_wdata,
   input  logic [7:0]        mem_byte_enable,
   input  logic              mem_ext_un,
   output logic              mem_done,
   output logic [63:0]       mem_rdata,
   output logic              mem_err,
   output logic              if_busy,
   output logic              mem_busy,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_wen,
   output logic [63:0]       bus_wdata,
   output logic [7:0]        bus_wmask,
   input  logic              bus_rvalid,
   input  logic [63:0]       bus_rdata
);

   localparam logic [7:0] WAIT_TC = 8'(MAX_WAIT - 1);

   arb_state_t        state_q, state_d;
   logic [7:0]        cnt_q;
   logic              is_mem_q, wen_q, ext_un_q, err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        wmask_q, be_q;
   logic [63:0]       wdata_q, rdata_q;
   logic [2:0]        off_q;

   logic              mem_req, mem_bad, timeout, resp;
   logic [2:0]        al_off;
   logic [7:0]        al_be, al_wmask;
   logic [63:0]       al_wdata_sh, al_rdata_ext;
   logic              al_misalign;

   // In IDLE the aligner looks at the live MEM request; afterwards at the latched one.
   assign al_off  = (state_q == ARB_IDLE) ? mem_addr[2:0]   : off_q;
   assign al_be   = (state_q == ARB_IDLE) ? mem_byte_enable : be_q;
   assign mem_req = mem_r_ena | mem_w_ena;
   assign mem_bad = al_misalign | ~be_legal(mem_byte_enable);
   // Timeout fires on the MAX_WAIT-th cycle spent in REQ+WAIT.
   assign timeout = (cnt_q == WAIT_TC);

   mem_bus_arbiter_align u_align (
      .off       (al_off),
      .be        (al_be),
      .ext_un    (ext_un_q),
      .wdata     (mem_wdata),
      .rdata     (rdata_q),
      .wmask     (al_wmask),
      .wdata_sh  (al_wdata_sh),
      .rdata_ext (al_rdata_ext),
      .misalign  (al_misalign)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ARB_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: begin
            if (mem_req)     state_d = mem_bad ? ARB_RESP : ARB_REQ;
            else if (if_req) state_d = ARB_REQ;
         end
         ARB_REQ: begin
            if (timeout)        state_d = ARB_RESP;
            else if (bus_ready) state_d = ARB_WAIT;
         end
         ARB_WAIT: begin
            if (bus_rvalid || timeout) state_d = ARB_RESP;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else if (state_q == ARB_REQ || state_q == ARB_WAIT) cnt_q <= cnt_q + 8'd1;
      else cnt_q <= '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         is_mem_q <= 1'b0;
         wen_q    <= 1'b0;
         ext_un_q <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         wmask_q  <= '0;
         be_q     <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         off_q    <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               rdata_q <= '0;
               if (mem_req) begin
                  is_mem_q <= 1'b1;
                  wen_q    <= mem_w_ena;
                  addr_q   <= {mem_addr[ADDR_W-1:3], 3'b000};
                  wmask_q  <= al_wmask;
                  wdata_q  <= mem_w_ena ? al_wdata_sh : '0;
                  off_q    <= mem_addr[2:0];
                  be_q     <= mem_byte_enable;
                  ext_un_q <= mem_ext_un;
                  err_q    <= mem_bad;
               end else if (if_req) begin
                  is_mem_q <= 1'b0;
                  wen_q    <= 1'b0;
                  addr_q   <= {if_addr[ADDR_W-1:3], 3'b000};
                  wmask_q  <= BE_D;
                  wdata_q  <= '0;
                  off_q    <= if_addr[2:0];
                  be_q     <= BE_D;
                  ext_un_q <= 1'b1;
                  err_q    <= 1'b0;
               end
            end
            ARB_REQ: begin
               if (timeout) err_q <= 1'b1;
            end
            ARB_WAIT: begin
               if (bus_rvalid)   rdata_q <= bus_rdata;
               else if (timeout) err_q   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign resp      = (state_q == ARB_RESP);
   assign bus_valid = (state_q == ARB_REQ);
   assign bus_addr  = bus_valid ? addr_q  : '0;
   assign bus_wen   = bus_valid & wen_q;
   assign bus_wmask = bus_valid ? wmask_q : '0;
   assign bus_wdata = bus_valid ? wdata_q : '0;

   assign if_done   = resp & ~is_mem_q;
   assign if_rdata  = (if_done & ~err_q) ? (off_q[2] ? rdata_q[63:32] : rdata_q[31:0]) : '0;
   assign mem_done  = resp & is_mem_q;
   assign mem_err   = mem_done & err_q;
   assign mem_rdata = (mem_done & ~err_q & ~wen_q) ? al_rdata_ext : '0;

   // Combinational so the stall releases in the same cycle as the done pulse.
   assign if_busy   = if_req & ~if_done;
   assign mem_busy  = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected bus requests and
// responses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [63:0] if_addr = '0;
   logic        if_done;
   logic [31:0] if_rdata;
   logic        mem_r_ena = 1'b0;
   logic        mem_w_ena = 1'b0;
   logic [63:0] mem_addr = '0;
   logic [63:0] mem_wdata = '0;
   logic [7:0]  mem_byte_enable = '0;
   logic        mem_ext_un = 1'b0;
   logic        mem_done;
   logic [63:0] mem_rdata;
   logic        mem_err;
   logic        if_busy, mem_busy;
   logic        bus_valid;
   logic        bus_ready = 1'b0;
   logic [63:0] bus_addr;
   logic        bus_wen;
   logic [63:0] bus_wdata;
   logic [7:0]  bus_wmask;
   logic        bus_rvalid = 1'b0;
   logic [63:0] bus_rdata = '0;

   typedef struct {
      logic [63:0] addr;
      logic        wen;
      logic [7:0]  wmask;
      logic [63:0] wdata;
   } bus_t;
   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } mresp_t;

   bus_t        exp_bus[$];
   logic [31:0] exp_if[$];
   mresp_t      exp_mem[$];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          req_cyc = 0;
   int          if_done_cyc = 0;
   int          mem_done_cyc = 0;
   int          hs_cyc = 0;
   int          prev_hs_cyc = 0;
   logic        rvalid_en = 1'b1;
   logic [63:0] slave_rdata = '0;

   mem_bus_arbiter #(.ADDR_W(64), .MAX_WAIT(255)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .mem_r_ena(mem_r_ena), .mem_w_ena(mem_w_ena), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable), .mem_ext_un(mem_ext_un),
      .mem_done(mem_done), .mem_rdata(mem_rdata), .mem_err(mem_err),
      .if_busy(if_busy), .mem_busy(mem_busy),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_wen(bus_wen),
      .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [136:0] act, input logic [136:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Slave: answers one cycle after an accepted request when rvalid_en is set.
   initial begin
      logic hs;
      forever begin
         @(negedge clk);
         hs = bus_valid & bus_ready;
         @(posedge clk);
         #1;
         bus_rvalid = 1'b0;
         bus_rdata  = '0;
         if (hs && rvalid_en) begin
            bus_rvalid = 1'b1;
            bus_rdata  = slave_rdata;
         end
      end
   end

   // Monitor
   always @(negedge clk) begin
      if (rst) begin
         if (bus_valid && bus_ready) begin
            prev_hs_cyc = hs_cyc;
            hs_cyc      = cyc;
            if (exp_bus.size() == 0) chk("bus_unexpected", 137'(bus_addr), 137'(0));
            else begin
               bus_t b;
               b = exp_bus.pop_front();
               chk("bus_req", {bus_addr, bus_wen, bus_wmask, bus_wdata},
                   {b.addr, b.wen, b.wmask, b.wdata});
            end
         end
         if (if_done) begin
            if_done_cyc = cyc;
            chk("if_busy_at_done", 137'(if_busy), 137'(0));
            if (exp_if.size() == 0) chk("if_done_unexpected", 137'(if_rdata), 137'(0));
            else chk("if_rdata", 137'(if_rdata), 137'(exp_if.pop_front()));
         end
         if (mem_done) begin
            mem_done_cyc = cyc;
            if (exp_mem.size() == 0) chk("mem_done_unexpected", 137'(mem_rdata), 137'(0));
            else begin
               mresp_t m;
               m = exp_mem.pop_front();
               chk("mem_resp", {mem_rdata, mem_err}, {m.rdata, m.err});
            end
         end
      end
   end

   task automatic run_until_done(input int budget);
      int   n;
      logic if_seen, mem_seen, busy_bad;
      n = 0;
      busy_bad = 1'b0;
      while ((if_req || mem_r_ena || mem_w_ena) && n < budget) begin
         @(negedge clk);
         if_seen  = if_done;
         mem_seen = mem_done;
         if (if_req && !if_done && !if_busy) busy_bad = 1'b1;
         if ((mem_r_ena || mem_w_ena) && !mem_done && !mem_busy) busy_bad = 1'b1;
         @(posedge clk);
         #1;
         if (if_seen) if_req = 1'b0;
         if (mem_seen) begin
            mem_r_ena = 1'b0;
            mem_w_ena = 1'b0;
         end
         n++;
      end
      chk("done_within_budget", 137'(if_req | mem_r_ena | mem_w_ena), 137'(0));
      chk("busy_while_pending", 137'(busy_bad), 137'(0));
      if_req = 1'b0;
      mem_r_ena = 1'b0;
      mem_w_ena = 1'b0;
   endtask

   task automatic mem_op(input logic wen, input logic [63:0] addr, input logic [7:0] be,
                         input logic un, input logic [63:0] wd, input logic [63:0] srd,
                         input logic exp_bus_req, input logic [7:0] exp_mask,
                         input logic [63:0] exp_wd, input logic [63:0] exp_rd,
                         input logic exp_err);
      bus_t   b;
      mresp_t m;
      b.addr = {addr[63:3], 3'b000};
      b.wen = wen;
      b.wmask = exp_mask;
      b.wdata = exp_wd;
      m.rdata = exp_rd;
      m.err = exp_err;
      if (exp_bus_req) exp_bus.push_back(b);
      exp_mem.push_back(m);
      slave_rdata = srd;
      @(posedge clk);
      #1;
      req_cyc = cyc;
      mem_addr = addr;
      mem_byte_enable = be;
      mem_ext_un = un;
      mem_wdata = wd;
      mem_w_ena = wen;
      mem_r_ena = ~wen;
      run_until_done(400);
   endtask

   task automatic if_op(input logic [63:0] addr, input logic [63:0] srd, input logic [31:0] exp_word);
      bus_t b;
      b.addr = {addr[63:3], 3'b000};
      b.wen = 1'b0;
      b.wmask = 8'hFF;
      b.wdata = '0;
      exp_bus.push_back(b);
      exp_if.push_back(exp_word);
      slave_rdata = srd;
      @(posedge clk);
      #1;
      req_cyc = cyc;
      if_addr = addr;
      if_req = 1'b1;
      run_until_done(400);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   initial begin
      bus_t   b;
      mresp_t m;
      repeat (3) @(negedge clk);
      chk("rst_ctrl", 137'({bus_valid, bus_wen, bus_wmask, if_done, mem_done, mem_err, if_busy, mem_busy}), 137'(0));
      chk("rst_data", 137'(bus_addr | bus_wdata | mem_rdata | {32'b0, if_rdata}), 137'(0));
      rst = 1'b1;
      bus_ready = 1'b1;
      rvalid_en = 1'b1;

      // Fetch from upper word, done exactly 3 cycles after the request
      if_op(64'h8000_0004, 64'h1111_2222_3333_4444, 32'h1111_2222);
      chk("if_latency", 137'(if_done_cyc - req_cyc), 137'(3));

      // Simultaneous fetch and load: MEM first, fetch handshake 4 cycles later
      b.addr = 64'h1000; b.wen = 1'b0; b.wmask = 8'hFF; b.wdata = '0;
      exp_bus.push_back(b);
      b.addr = 64'h2000;
      exp_bus.push_back(b);
      m.rdata = 64'hDEAD_BEEF_CAFE_F00D; m.err = 1'b0;
      exp_mem.push_back(m);
      exp_if.push_back(32'hCAFE_F00D);
      slave_rdata = 64'hDEAD_BEEF_CAFE_F00D;
      @(posedge clk);
      #1;
      req_cyc = cyc;
      if_addr = 64'h2000;
      if_req = 1'b1;
      mem_addr = 64'h1000;
      mem_byte_enable = 8'hFF;
      mem_ext_un = 1'b0;
      mem_r_ena = 1'b1;
      run_until_done(400);
      chk("mem_before_if", 137'(if_done_cyc > mem_done_cyc), 137'(1));
      chk("back_to_back_valid", 137'(hs_cyc - prev_hs_cyc), 137'(4));

      // Stores: lane-shifted mask and data, zero read data
      mem_op(1'b1, 64'h3005, 8'h01, 1'b0, 64'hAB, 64'hFFFF_FFFF_FFFF_FFFF,
             1'b1, 8'h20, 64'h0000_AB00_0000_0000, 64'h0, 1'b0);
      mem_op(1'b1, 64'h3004, 8'h0F, 1'b0, 64'h1234_5678, 64'h0,
             1'b1, 8'hF0, 64'h1234_5678_0000_0000, 64'h0, 1'b0);

      // Loads: alignment and extension
      mem_op(1'b0, 64'h4006, 8'h03, 1'b0, 64'h0, 64'h8001_1234_5678_9ABC,
             1'b1, 8'hC0, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
      mem_op(1'b0, 64'h4006, 8'h03, 1'b1, 64'h0, 64'h8001_1234_5678_9ABC,
             1'b1, 8'hC0, 64'h0, 64'h0000_0000_0000_8001, 1'b0);
      mem_op(1'b0, 64'h5003, 8'h01, 1'b0, 64'h0, 64'h1122_3344_7F66_7788,
             1'b1, 8'h08, 64'h0, 64'h0000_0000_0000_007F, 1'b0);
      mem_op(1'b0, 64'h5004, 8'h0F, 1'b0, 64'h0, 64'h8000_0000_1234_5678,
             1'b1, 8'hF0, 64'h0, 64'hFFFF_FFFF_8000_0000, 1'b0);
      mem_op(1'b0, 64'h5001, 8'h01, 1'b0, 64'h0, 64'h0000_0000_0000_8000,
             1'b1, 8'h02, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);

      // Errors without a bus transaction: lane crossing, bad mask, misaligned store
      mem_op(1'b0, 64'h6006, 8'h0F, 1'b0, 64'h0, 64'h1, 1'b0, 8'h00, 64'h0, 64'h0, 1'b1);
      mem_op(1'b0, 64'h6000, 8'h07, 1'b0, 64'h0, 64'h1, 1'b0, 8'h00, 64'h0, 64'h0, 1'b1);
      mem_op(1'b1, 64'h6001, 8'hFF, 1'b0, 64'h55, 64'h1, 1'b0, 8'h00, 64'h0, 64'h0, 1'b1);

      // Timeout: slave accepts but never responds
      rvalid_en = 1'b0;
      mem_op(1'b0, 64'h7000, 8'hFF, 1'b0, 64'h0, 64'h1234, 1'b1, 8'hFF, 64'h0, 64'h0, 1'b1);
      chk("mem_timeout_latency", 137'(mem_done_cyc - req_cyc), 137'(256));
      if_op(64'h7004, 64'h1234_5678_9ABC_DEF0, 32'h0);
      rvalid_en = 1'b1;

      // Reset while the request is stuck in REQ
      bus_ready = 1'b0;
      @(posedge clk);
      #1;
      mem_addr = 64'h9000;
      mem_byte_enable = 8'hFF;
      mem_r_ena = 1'b1;
      repeat (3) @(negedge clk);
      chk("stuck_in_req", 137'(bus_valid), 137'(1));
      mem_r_ena = 1'b0;
      rst = 1'b0;
      #1;
      chk("midrst_ctrl", 137'({bus_valid, bus_wen, bus_wmask, if_done, mem_done, mem_err, if_busy, mem_busy}), 137'(0));
      chk("midrst_data", 137'(bus_addr | bus_wdata | mem_rdata | {32'b0, if_rdata}), 137'(0));
      @(negedge clk);
      rst = 1'b1;
      bus_ready = 1'b1;
      mem_op(1'b0, 64'h8004, 8'h0F, 1'b1, 64'h0, 64'h8765_4321_0000_0000,
             1'b1, 8'hF0, 64'h0, 64'h0000_0000_8765_4321, 1'b0);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", 137'(exp_bus.size() + exp_if.size() + exp_mem.size()), 137'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
